// File: rtl/pixmix_pkg.sv
// Shared types and constants for the scanline pixel mixer: FSM states,
// default line length and the field layout of a line buffer word.
package pixmix_pkg;

    typedef enum logic [1:0] {
        MIX_IDLE  = 2'd0,
        MIX_PREP  = 2'd1,
        MIX_RUN   = 2'd2,
        MIX_DRAIN = 2'd3
    } mix_state_t;

    localparam int PIXMIX_NUM_PIXELS = 320;
    localparam int PIX_ADDR_W        = 9;

    // Line buffer word: {fg_sel, palette[3:0], color[3:0]}; the low byte
    // shares its layout with the tile engine pixel bytes.
    localparam int LB_WIDTH      = 9;
    localparam int LB_FG_SEL_POS = 8;
    localparam int LB_PAL_POS    = 4;
    localparam int LB_PAL_W      = 4;
    localparam int LB_COLOR_POS  = 0;
    localparam int LB_COLOR_W    = 4;

    function automatic logic is_opaque(input logic [7:0] px);
        return px[LB_COLOR_POS +: LB_COLOR_W] != '0;
    endfunction

endpackage

// File: rtl/pixmix_select.sv
// Priority select of one output pixel: opaque FG, else opaque BG, else backdrop.
// PIXMIX_BACKDROP_EN adds the backdrop input; otherwise transparent pixels give zero.
module pixmix_select
    import pixmix_pkg::*;
(
    input  logic [7:0]          bg_pixel_data,
    input  logic [7:0]          fg_pixel_data,
`ifdef PIXMIX_BACKDROP_EN
    input  logic [7:0]          backdrop,
`endif
    output logic [LB_WIDTH-1:0] mix_word
);

    always_comb begin
        mix_word = '0;
        if (is_opaque(fg_pixel_data)) begin
            mix_word[LB_FG_SEL_POS]              = 1'b1;
            mix_word[LB_PAL_POS +: LB_PAL_W]     = fg_pixel_data[LB_PAL_POS +: LB_PAL_W];
            mix_word[LB_COLOR_POS +: LB_COLOR_W] = fg_pixel_data[LB_COLOR_POS +: LB_COLOR_W];
        end
        else if (is_opaque(bg_pixel_data)) begin
            mix_word[LB_PAL_POS +: LB_PAL_W]     = bg_pixel_data[LB_PAL_POS +: LB_PAL_W];
            mix_word[LB_COLOR_POS +: LB_COLOR_W] = bg_pixel_data[LB_COLOR_POS +: LB_COLOR_W];
        end
`ifdef PIXMIX_BACKDROP_EN
        else begin
            mix_word[LB_PAL_POS +: LB_PAL_W]     = backdrop[LB_PAL_POS +: LB_PAL_W];
            mix_word[LB_COLOR_POS +: LB_COLOR_W] = backdrop[LB_COLOR_POS +: LB_COLOR_W];
        end
`endif
    end

endmodule

// File: rtl/pixel_mixer.sv
// Scanline composer: preps both tile engines, walks the pixel addresses and
// writes mixed pixels to the line buffer. PIXMIX_BACKDROP_EN enables the backdrop input.
module pixel_mixer
    import pixmix_pkg::*;
#(
    parameter int NUM_PIXELS = PIXMIX_NUM_PIXELS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  done,
    output logic                  bg_prep,
    output logic                  fg_prep,
    input  logic                  bg_done,
    input  logic                  fg_done,
    output logic [PIX_ADDR_W-1:0] pixel_addr,
    input  logic [7:0]            bg_pixel_data,
    input  logic [7:0]            fg_pixel_data,
`ifdef PIXMIX_BACKDROP_EN
    input  logic [7:0]            backdrop,
`endif
    output logic [PIX_ADDR_W-1:0] linebuf_addr,
    output logic [LB_WIDTH-1:0]   linebuf_wrdata,
    output logic                  linebuf_wren
);

    localparam logic [PIX_ADDR_W-1:0] LAST_ADDR = PIX_ADDR_W'(NUM_PIXELS - 1);

    mix_state_t state, state_next;
    logic start_accept, go_run, finish_line;
    logic bg_flag, fg_flag;
    logic issue_valid;
    logic [PIX_ADDR_W-1:0] issue_addr;
    logic [LB_WIDTH-1:0] mix_word;

`ifdef PIXMIX_BACKDROP_EN
    // Backdrop is captured at start so a mid-line change only affects the next line.
    logic [7:0] backdrop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            backdrop_q <= '0;
        else if (start_accept)
            backdrop_q <= backdrop;
    end
`endif

    pixmix_select u_select (
        .bg_pixel_data (bg_pixel_data),
        .fg_pixel_data (fg_pixel_data),
`ifdef PIXMIX_BACKDROP_EN
        .backdrop      (backdrop_q),
`endif
        .mix_word      (mix_word)
    );

    // A done arriving in the cycle it is seen counts, so RUN follows the later done directly.
    always_comb begin
        state_next   = state;
        start_accept = 1'b0;
        go_run       = 1'b0;
        finish_line  = 1'b0;
        case (state)
            MIX_IDLE: begin
                if (start && !done) begin
                    start_accept = 1'b1;
                    state_next   = MIX_PREP;
                end
            end
            MIX_PREP: begin
                if ((bg_flag || bg_done) && (fg_flag || fg_done)) begin
                    go_run     = 1'b1;
                    state_next = MIX_RUN;
                end
            end
            MIX_RUN: begin
                if (pixel_addr == LAST_ADDR)
                    state_next = MIX_DRAIN;
            end
            MIX_DRAIN: begin
                if (linebuf_wren && (linebuf_addr == LAST_ADDR)) begin
                    finish_line = 1'b1;
                    state_next  = MIX_IDLE;
                end
            end
            default: state_next = MIX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= MIX_IDLE;
            bg_prep        <= 1'b0;
            fg_prep        <= 1'b0;
            done           <= 1'b0;
            bg_flag        <= 1'b0;
            fg_flag        <= 1'b0;
            pixel_addr     <= '0;
            issue_valid    <= 1'b0;
            issue_addr     <= '0;
            linebuf_wren   <= 1'b0;
            linebuf_addr   <= '0;
            linebuf_wrdata <= '0;
        end
        else begin
            state   <= state_next;
            bg_prep <= start_accept;
            fg_prep <= start_accept;
            done    <= finish_line;
            bg_flag <= (state == MIX_PREP) && !go_run && (bg_flag || bg_done);
            fg_flag <= (state == MIX_PREP) && !go_run && (fg_flag || fg_done);

            if ((state == MIX_RUN) && (pixel_addr != LAST_ADDR))
                pixel_addr <= pixel_addr + 1'b1;
            else
                pixel_addr <= '0;

            // Two-stage write pipe: address out, engine data back, registered write.
            issue_valid    <= (state == MIX_RUN);
            issue_addr     <= pixel_addr;
            linebuf_wren   <= issue_valid;
            linebuf_addr   <= issue_valid ? issue_addr : '0;
            linebuf_wrdata <= issue_valid ? mix_word : '0;
        end
    end

endmodule

// File: tb/tb_pixel_mixer.sv
// Self-checking bench for pixel_mixer: table-driven mix vectors plus
// directed handshake, restart, done-collision and mid-line reset sequences.
module tb_pixel_mixer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       done;
    logic       bg_prep;
    logic       fg_prep;
    logic       bg_done;
    logic       fg_done;
    logic [8:0] pixel_addr;
    logic [7:0] bg_pixel_data;
    logic [7:0] fg_pixel_data;
    logic [8:0] linebuf_addr;
    logic [8:0] linebuf_wrdata;
    logic       linebuf_wren;
`ifdef PIXMIX_BACKDROP_EN
    logic [7:0] backdrop;
    localparam logic [8:0] TRANSPARENT = 9'h0A1;
`else
    localparam logic [8:0] TRANSPARENT = 9'h000;
`endif

    typedef struct {
        logic [7:0] fg;
        logic [7:0] bg;
        logic [8:0] exp;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] fg_mem[512];
    logic [7:0] bg_mem[512];
    logic [8:0] captured[512];

    int tests_run    = 0;
    int tests_failed = 0;

    int write_count, bad_writes, done_count, done_cycle, first_write;
    int bg_prep_count, fg_prep_count, prep_cycle, aborted;
    logic [8:0] prev_addr;

    pixel_mixer #(.NUM_PIXELS(320)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .done           (done),
        .bg_prep        (bg_prep),
        .fg_prep        (fg_prep),
        .bg_done        (bg_done),
        .fg_done        (fg_done),
        .pixel_addr     (pixel_addr),
        .bg_pixel_data  (bg_pixel_data),
        .fg_pixel_data  (fg_pixel_data),
`ifdef PIXMIX_BACKDROP_EN
        .backdrop       (backdrop),
`endif
        .linebuf_addr   (linebuf_addr),
        .linebuf_wrdata (linebuf_wrdata),
        .linebuf_wren   (linebuf_wren)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [8:0] mixModel(input logic [7:0] fg, input logic [7:0] bg);
        if (fg[3:0] != 4'h0) return {1'b1, fg};
        if (bg[3:0] != 4'h0) return {1'b0, bg};
        return TRANSPARENT;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic bgd, input logic fgd);
        start   = s;
        bg_done = bgd;
        fg_done = fgd;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_done"},    32'(done), 32'd0);
        checkOutput({tag, "_bg_prep"}, 32'(bg_prep), 32'd0);
        checkOutput({tag, "_fg_prep"}, 32'(fg_prep), 32'd0);
        checkOutput({tag, "_wren"},    32'(linebuf_wren), 32'd0);
        checkOutput({tag, "_pix_addr"}, 32'(pixel_addr), 32'd0);
        checkOutput({tag, "_lb_addr"}, 32'(linebuf_addr), 32'd0);
        checkOutput({tag, "_lb_data"}, 32'(linebuf_wrdata), 32'd0);
    endtask

    // Start pulses in cycle 0; engine dones and an optional extra start are
    // placed at given cycles. Observation happens #1 after each rising edge.
    task automatic runLine(input int bg_at, input int fg_at, input int restart_at,
                           input int abort_addr, input int budget);
        write_count = 0; bad_writes = 0; done_count = 0; done_cycle = -1;
        first_write = -1; bg_prep_count = 0; fg_prep_count = 0; prep_cycle = -1;
        aborted = 0; prev_addr = '0;
        for (int c = 0; c < budget; c++) begin
            if (bg_prep) begin
                bg_prep_count++;
                if (prep_cycle < 0) prep_cycle = c;
            end
            if (fg_prep) fg_prep_count++;
            if (linebuf_wren) begin
                if (first_write < 0) first_write = c;
                if (linebuf_addr != 9'(write_count))
                    bad_writes++;
                else if (linebuf_wrdata != mixModel(fg_mem[linebuf_addr], bg_mem[linebuf_addr]))
                    bad_writes++;
                captured[linebuf_addr] = linebuf_wrdata;
                write_count++;
            end
            if (done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (abort_addr >= 0 && first_write >= 0 && pixel_addr == 9'(abort_addr)) begin
                aborted = 1;
                break;
            end
            if (done_cycle >= 0 && c >= done_cycle + 5) break;
            applyStimulus(c == 0 || c == restart_at, c == bg_at, c == fg_at);
`ifdef PIXMIX_BACKDROP_EN
            backdrop = (c == 0) ? 8'hA1 : 8'h55;
`endif
            bg_pixel_data = bg_mem[prev_addr];
            fg_pixel_data = fg_mem[prev_addr];
            prev_addr     = pixel_addr;
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{fg: 8'h35, bg: 8'h72, exp: 9'h135};
        vecs[1] = '{fg: 8'h30, bg: 8'h72, exp: 9'h072};
        vecs[2] = '{fg: 8'h30, bg: 8'h40, exp: TRANSPARENT};
        vecs[3] = '{fg: 8'h0F, bg: 8'h00, exp: 9'h10F};
        vecs[4] = '{fg: 8'h00, bg: 8'h01, exp: 9'h001};
        vecs[5] = '{fg: 8'hF0, bg: 8'hF0, exp: TRANSPARENT};
        vecs[6] = '{fg: 8'hA5, bg: 8'h5A, exp: 9'h1A5};
        vecs[7] = '{fg: 8'h70, bg: 8'h8C, exp: 9'h08C};
        for (int a = 0; a < 512; a++) begin
            fg_mem[a]   = 8'(a * 7);
            bg_mem[a]   = 8'(a * 3 + 1);
            captured[a] = 9'h1FF;
        end
        for (int i = 0; i < 8; i++) begin
            fg_mem[i] = vecs[i].fg;
            bg_mem[i] = vecs[i].bg;
        end

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        bg_pixel_data = '0;
        fg_pixel_data = '0;
`ifdef PIXMIX_BACKDROP_EN
        backdrop = 8'h55;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Staggered dones: bg at +5, fg at +9, RUN from +10.
        runLine(5, 9, -1, -1, 400);
        checkOutput("a_prep_cycle", 32'(prep_cycle), 32'd1);
        checkOutput("a_bg_preps", 32'(bg_prep_count), 32'd1);
        checkOutput("a_fg_preps", 32'(fg_prep_count), 32'd1);
        checkOutput("a_first_write", 32'(first_write), 32'd12);
        checkOutput("a_writes", 32'(write_count), 32'd320);
        checkOutput("a_bad_writes", 32'(bad_writes), 32'd0);
        checkOutput("a_done_cycle", 32'(done_cycle), 32'd332);
        checkOutput("a_done_count", 32'(done_count), 32'd1);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("mix_vec%0d", i), 32'(captured[i]), 32'(vecs[i].exp));

        // Same-cycle dones.
        runLine(3, 3, -1, -1, 400);
        checkOutput("b_first_write", 32'(first_write), 32'd6);
        checkOutput("b_bg_preps", 32'(bg_prep_count), 32'd1);
        checkOutput("b_fg_preps", 32'(fg_prep_count), 32'd1);
        checkOutput("b_writes", 32'(write_count), 32'd320);
        checkOutput("b_done_cycle", 32'(done_cycle), 32'd326);

        // FG finishes before BG.
        runLine(7, 2, -1, -1, 400);
        checkOutput("c_first_write", 32'(first_write), 32'd10);
        checkOutput("c_done_cycle", 32'(done_cycle), 32'd330);
        checkOutput("c_bad_writes", 32'(bad_writes), 32'd0);

        // Second start during RUN is ignored.
        runLine(2, 2, 100, -1, 400);
        checkOutput("d_writes", 32'(write_count), 32'd320);
        checkOutput("d_bad_writes", 32'(bad_writes), 32'd0);
        checkOutput("d_done_count", 32'(done_count), 32'd1);
        checkOutput("d_bg_preps", 32'(bg_prep_count), 32'd1);
        checkOutput("d_done_cycle", 32'(done_cycle), 32'd325);

        // Start in the same cycle as done is ignored.
        runLine(2, 3, 326, -1, 400);
        checkOutput("e_done_cycle", 32'(done_cycle), 32'd326);
        checkOutput("e_bg_preps", 32'(bg_prep_count), 32'd1);
        checkOutput("e_fg_preps", 32'(fg_prep_count), 32'd1);
        checkOutput("e_done_count", 32'(done_count), 32'd1);

        // Asynchronous reset while pixel 150 is on the bus.
        runLine(2, 2, -1, 150, 400);
        checkOutput("f_abort_reached", 32'(aborted), 32'd1);
        checkOutput("f_writes_before_reset", 32'(write_count), 32'd149);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midrun");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            int stray_writes = 0;
            int stray_preps  = 0;
            for (int c = 0; c < 20; c++) begin
                applyStimulus(1'b0, c == 3, c == 5);
                @(posedge clk); #1;
                if (linebuf_wren) stray_writes++;
                if (bg_prep || fg_prep) stray_preps++;
            end
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("f_idle_writes", 32'(stray_writes), 32'd0);
            checkOutput("f_idle_preps", 32'(stray_preps), 32'd0);
        end
        runLine(4, 6, -1, -1, 400);
        checkOutput("g_first_write", 32'(first_write), 32'd9);
        checkOutput("g_writes", 32'(write_count), 32'd320);
        checkOutput("g_bad_writes", 32'(bad_writes), 32'd0);
        checkOutput("g_done_cycle", 32'(done_cycle), 32'd329);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
